// File: rtl/text_writer_pkg.sv
// Shared constants and state encoding for the text-mode write path.
package text_writer_pkg;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BLANK = 8'h20;

  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLR_ALL  = 2'd1,
    CLR_LINE = 2'd2
  } state_t;

endpackage

// File: rtl/text_writer.sv
// Byte-stream interpreter that writes character codes into the text RAM,
// tracking a cursor and clearing lines / the whole screen as required.
module text_writer
  import text_writer_pkg::*;
#(
  parameter int         COLS   = 40,
  parameter int         ROWS   = 17,
  parameter int         ADDR_W = 11,
  parameter logic [7:0] BLANK  = CH_BLANK
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [5:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

  localparam logic [5:0]        LAST_COL  = 6'(COLS - 1);
  localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

  state_t            state;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] clr_addr;
  logic [5:0]        clr_cnt;

  logic              accept;
  logic              is_print;
  logic              adv_line;
  logic [ADDR_W-1:0] cur_addr;
  logic [4:0]        next_row;
  logic [ADDR_W-1:0] next_base;

  always_comb begin
    accept    = in_valid && in_ready;
    is_print  = (in_data >= PRINT_MIN) && (in_data <= PRINT_MAX);
    adv_line  = accept && ((is_print && cursor_col == LAST_COL) || in_data == CH_LF);
    cur_addr  = row_base + ADDR_W'(cursor_col);
    // Running row base replaces a row*COLS multiplier; it wraps with the row.
    next_row  = (cursor_row == LAST_ROW) ? '0 : cursor_row + 5'd1;
    next_base = (cursor_row == LAST_ROW) ? '0 : row_base + COLS_A;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLR_ALL;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b1;
      cursor_col <= '0;
      cursor_row <= '0;
      row_base   <= '0;
      clr_addr   <= '0;
      clr_cnt    <= '0;
    end else begin
      wr_en <= 1'b0;
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          if (accept) begin
            if (is_print) begin
              wr_en      <= 1'b1;
              wr_addr    <= cur_addr;
              wr_data    <= in_data;
              cursor_col <= (cursor_col == LAST_COL) ? '0 : cursor_col + 6'd1;
            end else begin
              case (in_data)
                CH_CR: cursor_col <= '0;
                CH_LF: cursor_col <= '0;
                CH_BS: begin
                  if (cursor_col != '0) begin
                    cursor_col <= cursor_col - 6'd1;
                    wr_en      <= 1'b1;
                    wr_addr    <= cur_addr - 1'b1;
                    wr_data    <= BLANK;
                  end
                end
                CH_FF: begin
                  cursor_col <= '0;
                  cursor_row <= '0;
                  row_base   <= '0;
                  clr_addr   <= '0;
                  state      <= CLR_ALL;
                  in_ready   <= 1'b0;
                  busy       <= 1'b1;
                end
                default: ;
              endcase
            end
            if (adv_line) begin
              cursor_row <= next_row;
              row_base   <= next_base;
              clr_addr   <= next_base;
              clr_cnt    <= '0;
              state      <= CLR_LINE;
              in_ready   <= 1'b0;
              busy       <= 1'b1;
            end
          end
        end
        CLR_ALL: begin
          wr_en    <= 1'b1;
          wr_addr  <= clr_addr;
          wr_data  <= BLANK;
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == LAST_CELL) state <= IDLE;
        end
        CLR_LINE: begin
          wr_en    <= 1'b1;
          wr_addr  <= clr_addr;
          wr_data  <= BLANK;
          clr_addr <= clr_addr + 1'b1;
          clr_cnt  <= clr_cnt + 6'd1;
          if (clr_cnt == LAST_COL) state <= IDLE;
        end
        default: state <= CLR_ALL;
      endcase
    end
  end

endmodule

// File: tb/tb_text_writer.sv
// Scoreboard bench for text_writer: expected RAM writes are queued by the
// stimulus and matched by a negedge monitor; cursor/handshake checked inline.
module tb_text_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];

  text_writer #(.COLS(40), .ROWS(17), .ADDR_W(11), .BLANK(8'h20)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset === 1'b0 && wr_en === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, want no write", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          bad++;
          $display("FAIL ram_write: got addr=%0d data=%h, want addr=%0d data=%h",
                   wr_addr, wr_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic push_w(input int addr, input logic [7:0] data);
    wr_t e;
    e.addr = 11'(addr);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_clear(input int base, input int n);
    for (int i = 0; i < n; i++) push_w(base + i, 8'h20);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready", 32'(in_ready), 1);
    if (in_ready === 1'b1) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (in_ready !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_reached", 32'(in_ready), 1);
  endtask

  task automatic check_cursor(input string name, input int col, input int row);
    check({name, "_col"}, 32'(cursor_col), 32'(col));
    check({name, "_row"}, 32'(cursor_row), 32'(row));
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_busy", 32'(busy), 1);
    check_cursor("rst", 0, 0);

    // Power-up clear: 680 blanks, then ready one cycle after the last write
    push_clear(0, 680);
    reset = 1'b0;
    wait_idle(n);
    check("init_clear_cycles", 32'(n), 681);
    check("init_busy", 32'(busy), 0);
    check_cursor("init", 0, 0);
    check("init_queue_drained", 32'(exp_q.size()), 0);

    // Single printable
    push_w(0, 8'h41);
    send_byte(8'h41);
    check_cursor("char_A", 1, 0);

    // Down to row 2, then fill it
    push_clear(40, 40);
    send_byte(8'h0A);
    check_cursor("lf_row1", 0, 1);
    push_clear(80, 40);
    send_byte(8'h0A);
    check_cursor("lf_row2", 0, 2);
    for (int i = 0; i < 40; i++) begin
      push_w(80 + i, 8'(8'h30 + i));
      if (i == 39) push_clear(120, 40);
      send_byte(8'(8'h30 + i));
    end
    check_cursor("row2_full", 0, 3);
    check("line_clear_not_ready", 32'(in_ready), 0);
    check("line_clear_busy", 32'(busy), 1);
    // Held byte lands at the start of the freshly cleared row
    push_w(120, 8'h5A);
    send_byte(8'h5A);
    check_cursor("held_byte", 1, 3);

    // Walk to row 16, put cursor at col 5, then LF wraps to row 0
    for (int r = 4; r <= 16; r++) begin
      push_clear(r * 40, 40);
      send_byte(8'h0A);
    end
    for (int i = 0; i < 5; i++) begin
      push_w(640 + i, 8'(8'h61 + i));
      send_byte(8'(8'h61 + i));
    end
    check_cursor("row16_col5", 5, 16);
    push_clear(0, 40);
    send_byte(8'h0A);
    check_cursor("row_wrap", 0, 0);

    // CR at (7,0)
    for (int i = 0; i < 7; i++) begin
      push_w(i, 8'(8'h4B + i));
      send_byte(8'(8'h4B + i));
    end
    check_cursor("pre_cr", 7, 0);
    send_byte(8'h0D);
    check_cursor("cr", 0, 0);
    idle_cycles(3);
    check("cr_no_write", 32'(exp_q.size()), 0);

    // BS behaviour on row 4 and ignored bytes
    for (int r = 1; r <= 4; r++) begin
      push_clear(r * 40, 40);
      send_byte(8'h0A);
    end
    for (int i = 0; i < 3; i++) begin
      push_w(160 + i, 8'(8'h70 + i));
      send_byte(8'(8'h70 + i));
    end
    check_cursor("pre_bs", 3, 4);
    push_w(162, 8'h20);
    send_byte(8'h08);
    check_cursor("bs", 2, 4);
    send_byte(8'h0D);
    check_cursor("cr_row4", 0, 4);
    send_byte(8'h08);
    check_cursor("bs_col0", 0, 4);
    send_byte(8'h90);
    check_cursor("ignore_90", 0, 4);
    send_byte(8'h7F);
    check_cursor("ignore_7f", 0, 4);
    idle_cycles(3);
    check("ignored_no_write", 32'(exp_q.size()), 0);

    // FF mid-screen, then reset in the middle of the full clear
    push_w(160, 8'h51);
    send_byte(8'h51);
    check_cursor("pre_ff", 1, 4);
    push_clear(0, 680);
    send_byte(8'h0C);
    check_cursor("ff", 0, 0);
    check("ff_busy", 32'(busy), 1);
    n = 0;
    while (!(wr_en === 1'b1 && wr_addr === 11'd300) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("reach_cell_300", 32'(wr_addr), 300);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("midclr_rst_wr_en", 32'(wr_en), 0);
    check("midclr_rst_busy", 32'(busy), 1);
    check("midclr_rst_ready", 32'(in_ready), 0);
    check_cursor("midclr_rst", 0, 0);
    @(posedge clk); #1;
    push_clear(0, 680);
    reset = 1'b0;
    wait_idle(n);
    check("reclear_cycles", 32'(n), 681);
    check_cursor("final", 0, 0);
    check("final_busy", 32'(busy), 0);
    check("final_queue_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
